// File: rtl/dcache_mem_stage.sv
// Memory stage: direct-mapped write-through, no-write-allocate data cache
// in front of the byte-serial DRAM model; stalls the pipeline on DRAM traffic.
module dcache_mem_stage #(
   parameter int NUM_LINES  = 16,
   parameter int LINE_BYTES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_inst,
   input  logic [31:0] mem_addr,
   input  logic [31:0] exe_result,
   output logic        freeze_cpu,
   output logic [31:0] write_back_inst,
   output logic [31:0] mem_result,
   output logic [1:0]  dram_signal,
   output logic [31:0] dram_addr_rd,
   output logic [31:0] dram_addr_wr,
   output logic [7:0]  dram_write_data,
   input  logic        dram_ready,
   input  logic [7:0]  dram_result
);

   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 32 - OFF_W - IDX_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REFILL,
      S_WRITE,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [OFF_W-1:0]   cnt_q, cnt_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q [NUM_LINES];
   logic [TAG_W-1:0]   tag_d [NUM_LINES];
   logic [7:0]         data_q [NUM_LINES][LINE_BYTES];
   logic [7:0]         data_d [NUM_LINES][LINE_BYTES];
   logic [31:0]        wb_inst_q, wb_inst_d;
   logic [31:0]        res_q, res_d;

   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic               is_load, is_store, ld_unsigned;
   logic [1:0]         size;
   logic [31:0]        aligned, line_base;
   logic [OFF_W-1:0]   off, n_last;
   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   tag;
   logic               hit;
   logic [7:0]         ld_b [4];
   logic [7:0]         st_b [4];
   logic [31:0]        load_val;
   logic               unused_ok;

   assign opcode      = mem_inst[6:0];
   assign funct3      = mem_inst[14:12];
   assign is_load     = (opcode == 7'b0000011);
   assign is_store    = (opcode == 7'b0100011);
   assign ld_unsigned = (funct3 == 3'b100) || (funct3 == 3'b101);
   assign unused_ok   = ^{mem_inst[31:15], mem_inst[11:7]};

   // size: 0 byte, 1 half, 2 word; unknown funct3 falls back to word
   always_comb begin
      size = 2'd2;
      if (is_load) begin
         case (funct3)
            3'b000, 3'b100: size = 2'd0;
            3'b001, 3'b101: size = 2'd1;
            default:        size = 2'd2;
         endcase
      end else if (is_store) begin
         case (funct3)
            3'b000:  size = 2'd0;
            3'b001:  size = 2'd1;
            default: size = 2'd2;
         endcase
      end
   end

   always_comb begin
      aligned = mem_addr;
      n_last  = '0;
      case (size)
         2'd0: begin
            aligned = mem_addr;
            n_last  = '0;
         end
         2'd1: begin
            aligned = {mem_addr[31:1], 1'b0};
            n_last  = OFF_W'(1);
         end
         default: begin
            aligned = {mem_addr[31:2], 2'b00};
            n_last  = OFF_W'(3);
         end
      endcase
   end

   assign off       = aligned[OFF_W-1:0];
   assign idx       = mem_addr[OFF_W+IDX_W-1:OFF_W];
   assign tag       = mem_addr[31:OFF_W+IDX_W];
   assign line_base = {mem_addr[31:OFF_W], {OFF_W{1'b0}}};
   assign hit       = valid_q[idx] && (tag_q[idx] == tag);

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         ld_b[k] = data_q[idx][off + OFF_W'(k)];
         st_b[k] = exe_result[8*k +: 8];
      end
   end

   always_comb begin
      case (size)
         2'd0: load_val = ld_unsigned ? {24'd0, ld_b[0]}
                                      : {{24{ld_b[0][7]}}, ld_b[0]};
         2'd1: load_val = ld_unsigned ? {16'd0, ld_b[1], ld_b[0]}
                                      : {{16{ld_b[1][7]}}, ld_b[1], ld_b[0]};
         default: load_val = {ld_b[3], ld_b[2], ld_b[1], ld_b[0]};
      endcase
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      valid_d         = valid_q;
      tag_d           = tag_q;
      data_d          = data_q;
      freeze_cpu      = 1'b0;
      dram_signal     = 2'd0;
      dram_addr_rd    = '0;
      dram_addr_wr    = '0;
      dram_write_data = '0;
      unique case (state_q)
         S_IDLE: begin
            if (is_load && !hit) begin
               freeze_cpu   = 1'b1;
               state_d      = S_REFILL;
               cnt_d        = '0;
               valid_d[idx] = 1'b0;
            end else if (is_store) begin
               freeze_cpu = 1'b1;
               state_d    = S_WRITE;
               cnt_d      = '0;
            end
         end
         S_REFILL: begin
            freeze_cpu   = 1'b1;
            dram_signal  = 2'd1;
            dram_addr_rd = line_base + 32'(cnt_q);
            if (dram_ready) begin
               data_d[idx][cnt_q] = dram_result;
               if (cnt_q == OFF_W'(LINE_BYTES - 1)) begin
                  valid_d[idx] = 1'b1;
                  tag_d[idx]   = tag;
                  state_d      = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_WRITE: begin
            freeze_cpu      = 1'b1;
            dram_signal     = 2'd2;
            dram_addr_wr    = aligned + 32'(cnt_q);
            dram_write_data = st_b[cnt_q[1:0]];
            if (dram_ready) begin
               if (cnt_q == n_last) begin
                  // write-through: refresh the cached copy only on a hit
                  if (hit) begin
                     for (int k = 0; k < 4; k++) begin
                        if (OFF_W'(k) <= n_last)
                           data_d[idx][off + OFF_W'(k)] = st_b[k];
                     end
                  end
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      wb_inst_d = wb_inst_q;
      res_d     = res_q;
      if (!freeze_cpu) begin
         wb_inst_d = mem_inst;
         res_d     = is_load ? load_val : exe_result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         valid_q   <= '0;
         wb_inst_q <= 32'h0000_0013;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         wb_inst_q <= wb_inst_d;
         res_q     <= res_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_q  <= tag_d;
         data_q <= data_d;
      end
   end

   assign write_back_inst = wb_inst_q;
   assign mem_result      = res_q;

endmodule
